// File: rtl/t05_hist_reader_if.sv
// Bundle for t05_hist_reader: phase input, SRAM command/data and the (char, count) stream.
// master = the reader block, slave = SRAM/downstream side.
interface t05_hist_reader_if;
  logic [3:0]  en_state;
  logic [31:0] sram_in;
  logic        out_ready;
  logic [7:0]  hist_addr;
  logic [1:0]  wr_r_en;
  logic [31:0] sram_out;
  logic [7:0]  out_char;
  logic [31:0] out_count;
  logic        out_valid;
  logic [31:0] total;
  logic [8:0]  nz_count;
  logic        complete;

  modport master (
    input  en_state, sram_in, out_ready,
    output hist_addr, wr_r_en, sram_out, out_char, out_count, out_valid,
           total, nz_count, complete
  );

  modport slave (
    output en_state, sram_in, out_ready,
    input  hist_addr, wr_r_en, sram_out, out_char, out_count, out_valid,
           total, nz_count, complete
  );
endinterface

// File: rtl/t05_hist_reader.sv
// t05_hist_reader: scans the 256-entry frequency SRAM and streams non-zero (char, count) pairs.
// Optional macro T05_HIST_CLEAR_ON_READ_EN: write 0 back to every entry after it is read.
module t05_hist_reader #(
  parameter logic [3:0] EN_CODE  = 4'd2,
  parameter int         READ_LAT = 1
) (
  input logic               clk,
  input logic               rst,
  t05_hist_reader_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_EMIT, S_NEXT, S_CLR, S_DONE
  } state_t;

`ifdef T05_HIST_CLEAR_ON_READ_EN
  localparam state_t     S_POST = S_CLR;
  localparam logic [1:0] CMD_WR = 2'b10;
`else
  localparam state_t     S_POST = S_NEXT;
`endif
  localparam logic [1:0] CMD_IDLE = 2'b00;
  localparam logic [1:0] CMD_RD   = 2'b01;
  localparam logic [1:0] LAT_LAST = 2'(READ_LAT - 1);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_idx, w_idx;
  logic [1:0]  r_wait;
  logic        w_en, w_abort, w_xfer, w_rd_done;

  logic [7:0]  r_hist_addr, w_hist_addr;
  logic [1:0]  r_wr_r_en, w_wr_r_en;
  logic [7:0]  r_out_char, w_out_char;
  logic [31:0] r_out_count, w_out_count;
  logic        r_out_valid, w_out_valid;
  logic [31:0] r_total, w_total;
  logic [8:0]  r_nz_count, w_nz_count;
  logic        r_complete, w_complete;

  assign w_en      = (bus.en_state == EN_CODE);
  assign w_abort   = !w_en && (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_xfer    = r_out_valid && bus.out_ready;
  assign w_rd_done = (r_wait == LAT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_en) w_state_nxt = S_REQ;
      S_REQ:   w_state_nxt = S_WAIT;
      S_WAIT:  if (w_rd_done) w_state_nxt = (bus.sram_in == 32'd0) ? S_POST : S_EMIT;
      S_EMIT:  if (w_xfer) w_state_nxt = S_POST;
      S_NEXT:  w_state_nxt = (r_idx == 8'd255) ? S_DONE : S_REQ;
      S_CLR:   w_state_nxt = S_NEXT;
      S_DONE:  if (!w_en) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_abort) w_state_nxt = S_IDLE;
  end

  // Outputs are registered, so their next values are derived from the next state.
  always_comb begin
    w_idx       = r_idx;
    w_hist_addr = r_hist_addr;
    w_wr_r_en   = CMD_IDLE;
    w_out_char  = r_out_char;
    w_out_count = r_out_count;
    w_total     = r_total;
    w_nz_count  = r_nz_count;
    w_out_valid = (w_state_nxt == S_EMIT);
    w_complete  = (w_state_nxt == S_DONE);

    if (r_state == S_IDLE && w_en) begin
      w_idx      = 8'd0;
      w_total    = 32'd0;
      w_nz_count = 9'd0;
    end
    if (r_state == S_NEXT && w_state_nxt == S_REQ) w_idx = r_idx + 8'd1;
    if (r_state == S_WAIT && w_state_nxt == S_EMIT) begin
      w_total     = r_total + bus.sram_in;
      w_nz_count  = r_nz_count + 9'd1;
      w_out_char  = r_idx;
      w_out_count = bus.sram_in;
    end

    case (w_state_nxt)
      S_REQ: begin
        w_hist_addr = w_idx;
        w_wr_r_en   = CMD_RD;
      end
      S_WAIT: w_hist_addr = r_idx;
`ifdef T05_HIST_CLEAR_ON_READ_EN
      S_CLR: begin
        w_hist_addr = r_idx;
        w_wr_r_en   = CMD_WR;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx       <= 8'd0;
      r_wait      <= 2'd0;
      r_hist_addr <= 8'd0;
      r_wr_r_en   <= CMD_IDLE;
      r_out_char  <= 8'd0;
      r_out_count <= 32'd0;
      r_out_valid <= 1'b0;
      r_total     <= 32'd0;
      r_nz_count  <= 9'd0;
      r_complete  <= 1'b0;
    end else begin
      r_idx       <= w_idx;
      r_wait      <= (r_state == S_WAIT && w_state_nxt == S_WAIT) ? r_wait + 2'd1 : 2'd0;
      r_hist_addr <= w_hist_addr;
      r_wr_r_en   <= w_wr_r_en;
      r_out_char  <= w_out_char;
      r_out_count <= w_out_count;
      r_out_valid <= w_out_valid;
      r_total     <= w_total;
      r_nz_count  <= w_nz_count;
      r_complete  <= w_complete;
    end
  end

  assign bus.hist_addr = r_hist_addr;
  assign bus.wr_r_en   = r_wr_r_en;
  assign bus.sram_out  = 32'd0;
  assign bus.out_char  = r_out_char;
  assign bus.out_count = r_out_count;
  assign bus.out_valid = r_out_valid;
  assign bus.total     = r_total;
  assign bus.nz_count  = r_nz_count;
  assign bus.complete  = r_complete;

endmodule

// File: tb/tb_t05_hist_reader.sv
// Scoreboard bench for t05_hist_reader: SRAM model with configurable read latency,
// expected pairs queued by the stimulus and popped by a separate stream monitor.
module tb_t05_hist_reader;
`ifdef T05_HIST_CLEAR_ON_READ_EN
  localparam int RL = 2;
  localparam int EXP_WR = 256;
`else
  localparam int RL = 1;
  localparam int EXP_WR = 0;
`endif
  localparam logic [3:0] EN = 4'd2;

  logic clk;
  logic rst;
  t05_hist_reader_if bus();

  t05_hist_reader #(.EN_CODE(EN), .READ_LAT(RL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  logic [39:0] exp_q[$];

  // SRAM model: read data appears RL cycles after the request cycle.
  logic [31:0] mem [256];
  logic [31:0] pipe [3];
  always @(posedge clk) begin
    pipe[0] <= (bus.wr_r_en == 2'b01) ? mem[bus.hist_addr] : 32'hDEAD_BEEF;
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
    if (bus.wr_r_en == 2'b10) mem[bus.hist_addr] <= bus.sram_out;
  end
  assign bus.sram_in = pipe[RL-1];

  // Bus observers: read ordering, write-cycle count, illegal command.
  int rd_n = 0, rd_seq_err = 0, wr_n = 0, cmd_err = 0;
  logic [7:0] rd_last = 8'd0;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.wr_r_en == 2'b01) begin
        if (bus.hist_addr == 8'd0) rd_n = 1;
        else begin
          if (bus.hist_addr != rd_last + 8'd1) rd_seq_err++;
          rd_n++;
        end
        rd_last = bus.hist_addr;
      end
      if (bus.wr_r_en == 2'b10) wr_n++;
      if (bus.wr_r_en == 2'b11) cmd_err++;
    end
  end

  // Stream monitor: pops an expected pair per handshake and checks stall stability.
  logic        pv_valid = 1'b0, pv_xfer = 1'b0, pv_en = 1'b0;
  logic [7:0]  pv_char = 8'd0;
  logic [31:0] pv_count = 32'd0;
  logic [39:0] mon_e;
  always @(negedge clk) begin
    if (rst) begin
      pv_valid = 1'b0;
    end else begin
      if (pv_valid && !pv_xfer && pv_en) begin
        n_total++;
        if (!(bus.out_valid === 1'b1 && bus.out_char == pv_char && bus.out_count == pv_count)) begin
          n_bad++;
          $display("FAIL stall_hold: got v=%0b (%0d,%0h) want v=1 (%0d,%0h)",
                   bus.out_valid, bus.out_char, bus.out_count, pv_char, pv_count);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        n_total++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL pair_extra: got (%0d,%0h) want no pair", bus.out_char, bus.out_count);
        end else begin
          mon_e = exp_q.pop_front();
          if ({bus.out_char, bus.out_count} !== mon_e) begin
            n_bad++;
            $display("FAIL pair: got (%0d,%0h) want (%0d,%0h)",
                     bus.out_char, bus.out_count, mon_e[39:32], mon_e[31:0]);
          end
        end
      end
      pv_valid = bus.out_valid;
      pv_xfer  = bus.out_valid && bus.out_ready;
      pv_en    = (bus.en_state == EN);
      pv_char  = bus.out_char;
      pv_count = bus.out_count;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_addr"},  32'(bus.hist_addr), 0);
    chk({tag, "_cmd"},   32'(bus.wr_r_en), 0);
    chk({tag, "_wdata"}, bus.sram_out, 0);
    chk({tag, "_char"},  32'(bus.out_char), 0);
    chk({tag, "_count"}, bus.out_count, 0);
    chk({tag, "_valid"}, 32'(bus.out_valid), 0);
    chk({tag, "_total"}, bus.total, 0);
    chk({tag, "_nz"},    32'(bus.nz_count), 0);
    chk({tag, "_cmpl"},  32'(bus.complete), 0);
  endtask

  // kind 0: [65]=2 [66]=1 [67]=1; kind 1: all ones; kind 2: [0]=FFFFFFFF [1]=2
  task automatic load(input int kind);
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    case (kind)
      0: begin mem[65] = 32'd2; mem[66] = 32'd1; mem[67] = 32'd1; end
      1: for (int i = 0; i < 256; i++) mem[i] = 32'd1;
      default: begin mem[0] = 32'hFFFF_FFFF; mem[1] = 32'd2; end
    endcase
  endtask

  task automatic push_a();
    exp_q.push_back({8'd65, 32'd2});
    exp_q.push_back({8'd66, 32'd1});
    exp_q.push_back({8'd67, 32'd1});
  endtask

  task automatic wait_valid(input string tag);
    int b = 0;
    while (bus.out_valid !== 1'b1 && b < 200) begin tick(1); b++; end
    chk({tag, "_vld_seen"}, 32'(bus.out_valid), 1);
  endtask

  task automatic run_scan(input string tag, input logic [31:0] etot, input logic [8:0] enz,
                          input logic [31:0] mem_sum_raw, input int wr0);
    int b = 0;
    logic [31:0] s;
    bus.en_state = EN;
    while (bus.complete !== 1'b1 && b < 20000) begin tick(1); b++; end
    chk({tag, "_complete"}, 32'(bus.complete), 1);
    chk({tag, "_total"}, bus.total, etot);
    chk({tag, "_nz"}, 32'(bus.nz_count), 32'(enz));
    chk({tag, "_q_left"}, exp_q.size(), 0);
    chk({tag, "_rd_n"}, rd_n, 256);
    chk({tag, "_rd_last"}, 32'(rd_last), 255);
    tick(4);
    chk({tag, "_hold_cmpl"}, 32'(bus.complete), 1);
    chk({tag, "_no_wrap"}, rd_n, 256);
    chk({tag, "_addr_end"}, 32'(bus.hist_addr), 255);
    chk({tag, "_wr_cycles"}, wr_n - wr0, EXP_WR);
    s = 32'd0;
    for (int i = 0; i < 256; i++) s = s + mem[i];
    chk({tag, "_mem_sum"}, s, (EXP_WR == 0) ? mem_sum_raw : 32'd0);
    bus.en_state = 4'd0;
    tick(1);
    chk({tag, "_cmpl_clr"}, 32'(bus.complete), 0);
    chk({tag, "_total_kept"}, bus.total, etot);
  endtask

  initial begin
    int b;
    rst = 1'b0;
    bus.en_state = 4'd0;
    bus.out_ready = 1'b0;
    load(0);
    #2 rst = 1'b1;
    #1 chk_zero("reset");
    tick(2);
    rst = 1'b0;
    tick(3);
    chk("idle_cmd", 32'(bus.wr_r_en), 0);

    // Async reset in the middle of a scan at index 40.
    load(1);
    for (int i = 0; i < 40; i++) exp_q.push_back({8'(i), 32'd1});
    bus.out_ready = 1'b1;
    bus.en_state = EN;
    b = 0;
    while (!(bus.wr_r_en == 2'b01 && bus.hist_addr == 8'd40) && b < 2000) begin tick(1); b++; end
    chk("rst40_reached", 32'(bus.hist_addr), 40);
    chk("rst40_total_before", bus.total, 40);
    #1 rst = 1'b1;
    #1 chk_zero("rst40");
    bus.en_state = 4'd0;
    tick(2);
    rst = 1'b0;
    tick(3);
    chk("rst40_idle_cmd", 32'(bus.wr_r_en), 0);
    chk("rst40_q", exp_q.size(), 0);

    // Sparse table, out_ready held high.
    load(0);
    push_a();
    run_scan("sparse", 32'd4, 9'd3, 32'd4, wr_n);

    // Same table with a 5-cycle stall on the (66,1) pair.
    load(0);
    push_a();
    bus.out_ready = 1'b0;
    bus.en_state = EN;
    b = wr_n;
    for (int k = 0; k < 3; k++) begin
      wait_valid("stall");
      if (bus.out_char == 8'd66) tick(5);
      bus.out_ready = 1'b1;
      tick(1);
      bus.out_ready = 1'b0;
    end
    bus.out_ready = 1'b1;
    run_scan("stall", 32'd4, 9'd3, 32'd4, b);

    // All entries one.
    load(1);
    for (int i = 0; i < 256; i++) exp_q.push_back({8'(i), 32'd1});
    run_scan("ones", 32'd256, 9'd256, 32'd256, wr_n);

    // Total wraps modulo 2^32.
    load(2);
    exp_q.push_back({8'd0, 32'hFFFF_FFFF});
    exp_q.push_back({8'd1, 32'd2});
    run_scan("wrap", 32'd1, 9'd2, 32'd1, wr_n);

    // Abort while (66,1) is waiting in EMIT.
    load(0);
    exp_q.push_back({8'd65, 32'd2});
    bus.out_ready = 1'b0;
    bus.en_state = EN;
    wait_valid("abort65");
    bus.out_ready = 1'b1;
    tick(1);
    bus.out_ready = 1'b0;
    wait_valid("abort66");
    chk("abort_char", 32'(bus.out_char), 66);
    bus.en_state = 4'd0;
    tick(1);
    chk("abort_valid", 32'(bus.out_valid), 0);
    chk("abort_cmd", 32'(bus.wr_r_en), 0);
    chk("abort_cmpl", 32'(bus.complete), 0);
    chk("abort_total", bus.total, 3);
    chk("abort_nz", 32'(bus.nz_count), 2);
    tick(3);
    chk("abort_idle_cmd", 32'(bus.wr_r_en), 0);
    chk("abort_q", exp_q.size(), 0);
    load(0);
    push_a();
    bus.out_ready = 1'b1;
    bus.en_state = EN;
    tick(1);
    chk("restart_total", bus.total, 0);
    chk("restart_nz", 32'(bus.nz_count), 0);
    chk("restart_addr", 32'(bus.hist_addr), 0);
    chk("restart_cmd", 32'(bus.wr_r_en), 1);
    run_scan("restart", 32'd4, 9'd3, 32'd4, wr_n);

    chk("rd_sequence_err", rd_seq_err, 0);
    chk("rd_wr_same_cycle", cmd_err, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/t05_hist_reader.md
Name: t05_hist_reader

Overview:
- Read-side counterpart of the histogram builder. After a file has been tallied into the 256-entry SRAM frequency table, it scans addresses 0..255 in order.
- For each entry it issues an SRAM read and skips zero counts. Each non-zero entry goes out on a valid/ready stream as a (char, count) pair for the downstream tree builder.
- It also reports the summed total and the number of distinct symbols.

Parameters:
- EN_CODE, 4'd2, en_state value that enables this block.
- READ_LAT, 1, cycles from the read-request cycle to valid sram_in (1..3).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en_state  input  4  top-level phase; the block runs only while en_state == EN_CODE.
- sram_in  input  32  SRAM read data.
- out_ready  input  1  downstream accepts the current pair.
- hist_addr  output  8  SRAM word address (character code).
- wr_r_en  output  2  SRAM command: 00 idle, 01 read, 10 write.
- sram_out  output  32  SRAM write data; used only by the optional feature, otherwise 0.
- out_char  output  8  character of the current pair.
- out_count  output  32  count of the current pair.
- out_valid  output  1  pair valid.
- total  output  32  sum of all counts read, modulo 2^32.
- nz_count  output  9  number of non-zero entries, 0..256.
- complete  output  1  scan finished; held high.

Behaviour:
- Reset (async): state IDLE, idx 0, and every output 0 (hist_addr, wr_r_en, sram_out, out_char, out_count, out_valid, total, nz_count, complete).
- All outputs are registered.
- IDLE:
  - When en_state == EN_CODE: clear total, nz_count and idx, go to REQ.
  - Otherwise stay in IDLE.
- REQ: one cycle with hist_addr = idx and wr_r_en = 01. Next state WAIT.
- WAIT:
  - wr_r_en = 00, hist_addr holds idx.
  - After READ_LAT cycles counted from REQ, capture sram_in as cnt.
  - If cnt == 0, go to NEXT (no emit).
  - Otherwise: total += cnt, nz_count += 1, out_char = idx, out_count = cnt, out_valid = 1, go to EMIT.
- EMIT:
  - out_valid, out_char and out_count are held stable until out_valid & out_ready.
  - out_ready may already be high on the first EMIT cycle; the transfer then completes in that cycle.
  - On transfer: out_valid drops the next cycle and the state goes to NEXT (or CLR when the optional feature is compiled in).
- NEXT:
  - If idx == 255, go to DONE; no wrap-around to 0.
  - Otherwise idx += 1, go to REQ.
- DONE:
  - complete = 1; total and nz_count are frozen.
  - Stays in DONE while en_state == EN_CODE.
  - When en_state changes, complete clears and the state returns to IDLE.
  - Results stay readable until the next start.
- Abort: if en_state != EN_CODE in any state other than IDLE or DONE, the next cycle gives state IDLE, out_valid 0, wr_r_en 00, complete 0. total and nz_count keep their partial values.
- Throughput with no stall: 3 + READ_LAT cycles per non-zero entry, 2 + READ_LAT per zero entry.
- total wraps modulo 2^32; there is no saturation and no flag.
- nz_count is 9 bits so that 256 fits.
- The block never issues a read and a write in the same cycle.

Optional Feature:
- Macro: T05_HIST_CLEAR_ON_READ_EN.
- Defined:
  - After each entry, an extra CLR state drives hist_addr = idx, wr_r_en = 10, sram_out = 0 for one cycle, then goes to NEXT.
  - CLR applies to zero entries too; every entry is cleared.
  - At DONE the whole table is 0, ready for the next file.
  - Adds 1 cycle per entry.
- Undefined: there is no CLR state, wr_r_en never equals 10, and sram_out is constant 0.

Test Plan:
- Reset mid-scan at idx 40 → all outputs 0 within the same cycle (async); idle until en_state == EN_CODE again.
- SRAM model with [65]=2, [66]=1, [67]=1, all other entries 0, out_ready held 1 → exactly three pairs in order (65,2), (66,1), (67,1); total 4, nz_count 3, complete rises; no pair for any zero entry.
- Same table with out_ready low for 5 cycles on the (66,1) pair → out_valid stays 1 and data stays stable across the stall; no duplicate or lost pair; final totals unchanged.
- All 256 entries = 1 → 256 pairs, nz_count 256; [0]=32'hFFFF_FFFF and [1]=2, rest 0 → total 1 (wrap); last address read is 255 and hist_addr never wraps.
- en_state leaves EN_CODE while in EMIT at char 66 → out_valid drops next cycle, state IDLE, complete stays 0; re-enable restarts from address 0 with totals cleared.
- With T05_HIST_CLEAR_ON_READ_EN defined, READ_LAT = 2 → after DONE every SRAM model entry is 0, with exactly 256 wr_r_en=10 cycles; without the macro, zero write cycles and the model is unchanged.
